// File: rtl/mask2strb.sv
// rtl/mask2strb.sv - coalesces aligned NoC store pieces into one 64-bit strobed write beat (option: MASK2STRB_ERR_CHECK_EN)

`ifndef MSG_DATA_SIZE_0B
`define MSG_DATA_SIZE_0B 3'b000
`endif
`ifndef MSG_DATA_SIZE_1B
`define MSG_DATA_SIZE_1B 3'b001
`endif
`ifndef MSG_DATA_SIZE_2B
`define MSG_DATA_SIZE_2B 3'b010
`endif
`ifndef MSG_DATA_SIZE_4B
`define MSG_DATA_SIZE_4B 3'b011
`endif
`ifndef MSG_DATA_SIZE_8B
`define MSG_DATA_SIZE_8B 3'b100
`endif

module mask2strb #(
  parameter int FLUSH_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [63:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [63:0] i_data,
  input  logic        i_last,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [63:0] o_addr,
  output logic [63:0] o_data,
  output logic [7:0]  o_strb,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  // Last counter value before an idle partial beat is flushed.
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((FLUSH_TIMEOUT > 0) ? (FLUSH_TIMEOUT - 1) : 0);
  localparam bit               C_TO_EN   = (FLUSH_TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [60:0]      r_line;
  logic [63:0]      r_data;
  logic [7:0]       r_strb;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_len;
  logic [3:0]       w_eff_len;
  logic [2:0]       w_lane;
  logic             w_piece_err;
  logic             w_same_line;
  logic             w_accept;

  logic [7:0]       w_len_mask;
  logic [7:0]       w_piece_strb;
  logic [63:0]      w_piece_data;
  logic [63:0]      w_base_data;
  logic [7:0]       w_base_strb;
  logic [63:0]      w_new_data;
  logic [7:0]       w_new_strb;

  logic             w_ready;
  logic             w_latch_line;
  logic             w_flush_done;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  assign w_lane      = i_addr[2:0];
  assign w_same_line = (i_addr[63:3] == r_line);
  assign w_accept    = i_valid && w_ready;

  // Byte count of the incoming piece; unknown sizes contribute no bytes.
  always_comb begin
    w_len = 4'd0;
    case (i_size)
      `MSG_DATA_SIZE_0B: w_len = 4'd0;
      `MSG_DATA_SIZE_1B: w_len = 4'd1;
      `MSG_DATA_SIZE_2B: w_len = 4'd2;
      `MSG_DATA_SIZE_4B: w_len = 4'd4;
      `MSG_DATA_SIZE_8B: w_len = 4'd8;
      default:           w_len = 4'd0;
    endcase
  end

`ifdef MASK2STRB_ERR_CHECK_EN
  logic w_size_bad;
  logic w_misaligned;

  assign w_size_bad   = (i_size > `MSG_DATA_SIZE_8B);
  // A piece of n bytes must start on an n-byte boundary; 8B wraps to mask 3'b111.
  assign w_misaligned = (w_len != 4'd0) && ((w_lane & (w_len[2:0] - 3'd1)) != 3'd0);
  assign w_piece_err  = w_size_bad || w_misaligned;
`else
  assign w_piece_err  = 1'b0;
`endif

  // Faulty pieces are still consumed but leave the buffer untouched.
  assign w_eff_len = w_piece_err ? 4'd0 : w_len;

  // Piece bytes moved to their lanes; anything beyond lane 7 falls off the top.
  assign w_len_mask   = 8'hFF >> (4'd8 - w_eff_len);
  assign w_piece_strb = w_len_mask << w_lane;
  assign w_piece_data = i_data << {w_lane, 3'b000};

  // A piece accepted from IDLE starts a fresh beat, otherwise it merges over the buffer.
  always_comb begin
    w_base_data = (r_state == S_IDLE) ? 64'd0 : r_data;
    w_base_strb = (r_state == S_IDLE) ? 8'd0  : r_strb;
    w_new_data  = w_base_data;
    w_new_strb  = w_base_strb | w_piece_strb;
    for (int k = 0; k < 8; k++) begin
      if (w_piece_strb[k]) begin
        w_new_data[8*k +: 8] = w_piece_data[8*k +: 8];
      end
    end
  end

  // Next-state and handshake control for IDLE/ACCUM/EMIT.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_latch_line = 1'b0;
    w_flush_done = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready   = 1'b1;
        w_cnt_clr = 1'b1;
        if (i_valid) begin
          w_latch_line = 1'b1;
          if (!i_last) begin
            w_state_nxt = S_ACCUM;
          end else if (w_eff_len != 4'd0) begin
            w_state_nxt = S_EMIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_ACCUM: begin
        w_ready = w_same_line;
        if (i_valid && w_same_line) begin
          w_cnt_clr = 1'b1;
          if (i_last) begin
            w_state_nxt = S_EMIT;
          end
        end else if (i_valid) begin
          // A piece for another line closes the current beat; it is taken from IDLE later.
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_EMIT;
        end else if (C_TO_EN && (r_cnt == C_TO_LAST)) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_EMIT;
        end else if (C_TO_EN) begin
          w_cnt_inc = 1'b1;
        end
      end
      S_EMIT: begin
        w_cnt_clr = 1'b1;
        if (o_ready) begin
          w_flush_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat buffer: line, byte lanes and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= 61'd0;
      r_data <= 64'd0;
      r_strb <= 8'd0;
    end else begin
      if (w_latch_line) begin
        r_line <= i_addr[63:3];
      end
      if (w_flush_done) begin
        r_data <= 64'd0;
        r_strb <= 8'd0;
      end else if (w_accept) begin
        r_data <= w_new_data;
        r_strb <= w_new_strb;
      end
    end
  end

  // Idle-cycle counter for flushing a stalled partial beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef MASK2STRB_ERR_CHECK_EN
  logic r_err;

  // Sticky flag for any consumed piece that failed the size/alignment check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_piece_err) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign i_ready = w_ready;
  assign o_valid = (r_state == S_EMIT);
  assign o_addr  = {r_line, 3'b000};
  assign o_data  = r_data;
  assign o_strb  = r_strb;

endmodule

// File: tb/tb_mask2strb.sv
// tb/tb_mask2strb.sv - directed table and sequence checks for mask2strb

module tb_mask2strb;

  localparam logic [2:0] SZ0  = 3'b000;
  localparam logic [2:0] SZ1  = 3'b001;
  localparam logic [2:0] SZ2  = 3'b010;
  localparam logic [2:0] SZ4  = 3'b011;
  localparam logic [2:0] SZ8  = 3'b100;
  localparam logic [2:0] SZ16 = 3'b101;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic        last;
    logic [63:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [63:0] i_addr;
  logic [2:0]  i_size;
  logic [63:0] i_data;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [63:0] o_addr;
  logic [63:0] o_data;
  logic [7:0]  o_strb;
  logic        o_err;

  int n_pass  = 0;
  int n_total = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  mask2strb #(.FLUSH_TIMEOUT(4), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_addr  (i_addr),
    .i_size  (i_size),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_addr  (o_addr),
    .o_data  (o_data),
    .o_strb  (o_strb),
    .o_err   (o_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one piece for one clock edge; it must be accepted.
  task automatic put(input logic [63:0] a, input logic [2:0] s, input logic [63:0] d, input logic l);
    i_valid = 1'b1;
    i_addr  = a;
    i_size  = s;
    i_data  = d;
    i_last  = l;
    #1;
    chk($sformatf("i_ready for piece @0x%0h", a), i_ready, 1);
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Check the presented beat, then complete its handshake.
  task automatic take(input string name, input logic [63:0] ea, input logic [7:0] es, input logic [63:0] ed);
    chk({name, " o_valid"}, o_valid, 1);
    chk({name, " o_addr"}, o_addr, ea);
    chk({name, " o_strb"}, o_strb, es);
    chk({name, " o_data"}, o_data, ed);
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    chk({name, " o_valid after handshake"}, o_valid, 0);
    chk({name, " o_strb cleared"}, o_strb, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_addr  = 64'd0;
    i_size  = SZ0;
    i_data  = 64'd0;
    i_last  = 1'b0;
    o_ready = 1'b0;

    tbl.push_back('{64'h1000, SZ8, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h1000, 8'hFF, 64'h0123_4567_89AB_CDEF});
    tbl.push_back('{64'h40, SZ1, 64'h11,   1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h42, SZ2, 64'h3322, 1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h45, SZ1, 64'h55,   1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h46, SZ1, 64'h66,   1'b1, 64'h40, 8'h6D, 64'h0066_5500_3322_0011});
    tbl.push_back('{64'h80, SZ4, 64'hDDCC_BBAA, 1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h81, SZ1, 64'hEE,        1'b1, 64'h80, 8'h0F, 64'h0000_0000_DDCC_EEAA});
    tbl.push_back('{64'hFFFF_FFFF_FFFF_FFF8, SZ8, 64'h1122_3344_5566_7788, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'h1122_3344_5566_7788});
    tbl.push_back('{64'h3006, SZ2, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h3001, SZ1, 64'hFFFF_FFFF_FFFF_FF5A, 1'b1, 64'h3000, 8'hC2, 64'hBEEF_0000_0000_5A00});
    tbl.push_back('{64'h500, SZ0, 64'hDEAD_BEEF, 1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h504, SZ4, 64'h1122_3344, 1'b1, 64'h500, 8'hF0, 64'h1122_3344_0000_0000});
`ifndef MASK2STRB_ERR_CHECK_EN
    tbl.push_back('{64'h02,  SZ4,  64'hA1B2_C3D4, 1'b1, 64'h0, 8'h3C, 64'h0000_A1B2_C3D4_0000});
    tbl.push_back('{64'h600, SZ16, 64'hFFFF_FFFF, 1'b0, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{64'h603, SZ1,  64'h77,        1'b1, 64'h600, 8'h08, 64'h0000_0000_7700_0000});
    tbl.push_back('{64'h704, SZ8,  64'h8877_6655_4433_2211, 1'b1, 64'h700, 8'hF0, 64'h4433_2211_0000_0000});
`endif

    step();
    step();
    chk("reset o_valid", o_valid, 0);
    chk("reset o_addr", o_addr, 0);
    chk("reset o_data", o_data, 0);
    chk("reset o_strb", o_strb, 0);
    chk("reset o_err", o_err, 0);
    chk("reset i_ready", i_ready, 1);
    rst_n = 1'b1;
    step();

    // o_ready with nothing presented is ignored
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    chk("idle o_ready o_valid", o_valid, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      put(tbl[i].addr, tbl[i].size, tbl[i].data, tbl[i].last);
      if (tbl[i].last) take($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_strb, tbl[i].e_data);
    end

    // 0B last from IDLE: nothing emitted
    put(64'h900, SZ0, 64'h1234, 1'b1);
    chk("0B last no beat", o_valid, 0);
    step();
    chk("0B last still idle", o_valid, 0);

    // different line during ACCUM closes the partial beat, EMIT stalls 5 cycles
    put(64'h2004, SZ4, 64'hAABB_CCDD, 1'b0);
    i_valid = 1'b1;
    i_addr  = 64'h2008;
    i_size  = SZ1;
    i_data  = 64'h99;
    i_last  = 1'b1;
    #1;
    chk("other line i_ready", i_ready, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d o_valid", c), o_valid, 1);
      chk($sformatf("stall%0d o_addr", c), o_addr, 64'h2000);
      chk($sformatf("stall%0d o_strb", c), o_strb, 8'hF0);
      chk($sformatf("stall%0d o_data", c), o_data, 64'hAABB_CCDD_0000_0000);
      chk($sformatf("stall%0d i_ready", c), i_ready, 0);
      step();
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    chk("partial handshake o_valid", o_valid, 0);
    chk("partial handshake o_strb", o_strb, 0);
    chk("held piece i_ready", i_ready, 1);
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
    take("held piece beat", 64'h2008, 8'h01, 64'h99);

    // idle flush after 4 idle cycles
    put(64'h10, SZ2, 64'hCAFE, 1'b0);
    step();
    step();
    step();
    chk("timeout 3 idle o_valid", o_valid, 0);
    step();
    take("timeout beat", 64'h10, 8'h03, 64'hCAFE);

    // same-line accept restarts the idle count
    put(64'h20, SZ1, 64'hA1, 1'b0);
    step();
    step();
    put(64'h21, SZ1, 64'hB2, 1'b0);
    step();
    step();
    step();
    chk("timeout restart o_valid", o_valid, 0);
    step();
    take("timeout restart beat", 64'h20, 8'h03, 64'hB2A1);

    // reset mid-ACCUM discards the partial beat
    put(64'h30, SZ1, 64'h77, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid reset o_valid", o_valid, 0);
    chk("mid reset o_strb", o_strb, 0);
    chk("mid reset o_data", o_data, 0);
    chk("mid reset i_ready", i_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    put(64'h31, SZ1, 64'h42, 1'b1);
    take("after reset beat", 64'h30, 8'h02, 64'h4200);

`ifdef MASK2STRB_ERR_CHECK_EN
    put(64'h02, SZ4, 64'hA1B2_C3D4, 1'b1);
    chk("err piece no beat", o_valid, 0);
    chk("err flag set", o_err, 1);
    step();
    chk("err flag sticky", o_err, 1);
    put(64'h08, SZ8, 64'h0102_0304_0506_0708, 1'b1);
    take("beat after err", 64'h08, 8'hFF, 64'h0102_0304_0506_0708);
    chk("err flag still set", o_err, 1);
`else
    chk("no err flag", o_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
